// File: rtl/mem_stage_pipe.sv
// Memory stage between execute and writeback: handshaked data port with byte lanes,
// sub-word load extraction, misalign/bus-timeout detection and the M/W register.
module mem_stage_pipe #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [2:0]        Funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [REG_W-1:0]  RdM,
  input  logic [31:0]       PCPlus4M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [ADDR_W-1:0] ALUResultW,
  output logic [31:0]       ReadDataW,
  output logic [REG_W-1:0]  RdW,
  output logic [31:0]       PCPlus4W,
  output logic              MisalignW,
  output logic              BusErrW
);
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_memop, w_load, w_misalign, w_req, w_timeout, w_buserr, w_stall, w_rd_done;
  logic [1:0]  w_off;
  logic [31:0] w_shifted, w_load_data;

  // Access classification and handshake control
  always_comb begin
    w_off      = ALUResultM[1:0];
    w_memop    = MemReadM | MemWriteM;
    w_load     = MemReadM & ~MemWriteM;
    w_misalign = ((Funct3M[1:0] == 2'b01) & w_off[0]) | (Funct3M[1] & (w_off != 2'b00));
    w_req      = ~rst & ((r_state == S_WAIT) | (w_memop & ~w_misalign));
    w_timeout  = TO_EN & (r_state == S_WAIT) & (r_cnt == CNT_W'(TIMEOUT));
    w_buserr   = w_req & ~mem_ready & w_timeout;
    w_stall    = w_req & ~mem_ready & ~w_timeout;
    w_rd_done  = w_req & mem_ready & w_load;
  end

  assign mem_req  = w_req;
  assign mem_we   = w_req & MemWriteM;
  assign mem_addr = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign StallM   = w_stall;

  // Store lane steering; loads read the whole word
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << w_off;
          mem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << w_off;
          mem_wdata = {2{WriteDataM[15:0]}};
        end
        default: mem_be = 4'b1111;
      endcase
    end
    if (!w_req) mem_be = 4'b0000;
  end

  // Sub-word load extraction with sign/zero extension
  always_comb begin
    w_shifted = mem_rdata >> {w_off, 3'b000};
    case (Funct3M[1:0])
      2'b00:   w_load_data = {{24{w_shifted[7] & ~Funct3M[2]}}, w_shifted[7:0]};
      2'b01:   w_load_data = {{16{w_shifted[15] & ~Funct3M[2]}}, w_shifted[15:0]};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_stall) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (w_stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // M/W register: bubble while stalled, capture on every non-stalled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else if (w_stall) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
      BusErrW   <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~(w_memop & w_misalign) & ~w_buserr;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= w_rd_done ? w_load_data : 32'h0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= w_memop & w_misalign;
      BusErrW    <= w_buserr;
    end
  end
endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised successor to the current memory stage, covering the stage between execute and writeback. It drives a handshaked data-memory port with byte enables. It performs sub-word load extraction with sign/zero extension and detects misaligned accesses. It stalls the pipeline on wait states, applies a bus timeout, and registers everything into the M/W pipeline register with stall-bubble insertion.

Parameters:
ADDR_W, 32, width of ALUResultM / mem_addr
REG_W, 5, destination register index width
TIMEOUT, 16, max wait cycles before bus error (0 = no timeout)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RegWriteM  in  1  register write enable from EX/M
ResultSrcM  in  2  writeback mux select
MemWriteM  in  1  store
MemReadM  in  1  load
Funct3M  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  ADDR_W  effective address / ALU result
WriteDataM  in  32  store data (rs2)
RdM  in  REG_W  destination register
PCPlus4M  in  32  PC+4
mem_req  out  1  memory request
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_rdata  in  32  read data, valid with mem_ready
mem_ready  in  1  access complete this cycle
StallM  out  1  freeze F/D/E/M stages
RegWriteW  out  1
ResultSrcW  out  2
ALUResultW  out  ADDR_W
ReadDataW  out  32  extended load data
RdW  out  REG_W
PCPlus4W  out  32
MisalignW  out  1  misaligned access flagged
BusErrW  out  1  timeout flagged

Behaviour:
- Reset: FSM=IDLE, wait counter=0. All W outputs 0. mem_req=0, StallM=0.
- memop = MemReadM|MemWriteM.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Misaligned memop: no mem_req. Complete in one cycle with RegWriteW=0 and MisalignW=1.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - Loads drive be=1111, we=0.
- Load extract: byte = rdata>>(8*addr[1:0]), half = rdata>>(8*addr[1:0]). Sign- or zero-extend per Funct3M.
- FSM IDLE:
  - Aligned memop: mem_req=1 combinationally.
  - If mem_ready in the same cycle: zero-wait completion, StallM=0, stay IDLE.
  - Else: StallM=1, go WAIT, counter=1.
- FSM WAIT:
  - mem_req=1 and StallM=1. Address, be, wdata and we are held stable (M inputs are frozen by the stall).
  - mem_ready: completion, StallM=0, go IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT: complete with BusErrW=1 and RegWriteW=0, StallM=0, go IDLE.
  - Else counter+1.
- W register:
  - Updates every cycle StallM=0. On completion it captures the M fields plus ReadDataW (0 for non-loads).
  - While StallM=1 it loads a bubble: RegWriteW=0, MisalignW=0, BusErrW=0; other fields don't-care/held.
- Non-memop: single cycle, passes through, no mem_req.
- mem_ready with no request outstanding: ignored.
- Reset mid-WAIT: IDLE next cycle, mem_req drops, pending access abandoned.

Test Plan:
- LW addr 0x100, mem_ready same cycle, rdata 0xDEADBEEF -> StallM never high; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB addr 0x103, rdata 0x80FF1234, ready after 3 cycles -> StallM high 3 cycles with bubbles (RegWriteW=0); then ReadDataW=0xFFFFFF80. LBU on the same access -> 0x00000080.
- SH addr 0x0A, WriteDataM=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, RegWriteW=0.
- LW addr 0x102 -> mem_req stays 0; next cycle MisalignW=1, RegWriteW=0, no stall.
- LW, mem_ready never asserted, TIMEOUT=16 -> StallM high for exactly 16 cycles, then BusErrW=1 pulse, FSM back in IDLE.
- rst asserted in 2nd WAIT cycle -> next cycle mem_req=0, StallM=0, all W outputs 0; a following ADD result (RegWriteM=1) passes through in 1 cycle.
